wb_sevenseg_scan: RTL and testbench

//  Wishbone-controlled scan controller for a multiplexed common-anode seven-segment display.

---
 rtl/wb_sevenseg_scan.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_wb_sevenseg_scan.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// wb_sevenseg_scan
//
// Wishbone-controlled scan controller for a multiplexed common-anode
// seven-segment display. Two bus registers:
//   word 0  VALUE  32-bit hex value, digit k shows VALUE[4k+3:4k]
//   word 1  CTRL   bit0 EN (scan enable), bit1 LZB (leading-zero blanking),
//                  bits[15:8] DP (decimal point mask, bit k for digit k)
// Each digit slot lasts CLK_DIV clocks: BLANK_CYC clocks with every anode off
// (segments settle, no ghosting), then the digit's anode is on for the rest.
// VALUE and DP are copied into a shadow at the start of every slot so a digit
// never tears while it is lit.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_wb_cyc/stb/we         Wishbone request
//   i_wb_addr[29:0]         word address, only bit 0 decoded
//   i_wb_data[31:0]         write data
//   i_wb_sel[3:0]           byte enables
//   o_wb_ack                response, one cycle after each accepted strobe
//   o_wb_stall              always 0
//   o_wb_data[31:0]         registered read data
//   o_seg[6:0]              segments {g,f,e,d,c,b,a}
//   o_dp                    decimal point
//   o_an[NDIGITS-1:0]       digit enables, one-hot while a digit is lit
// Polarity of o_seg/o_dp/o_an is set by SEG_ACTIVE_LOW (1: active-low).
// -----------------------------------------------------------------------------
module wb_sevenseg_scan #(
    parameter int NDIGITS        = 8,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [29:0]        i_wb_addr,
    input  logic [31:0]        i_wb_data,
    input  logic [3:0]         i_wb_sel,
    output logic               o_wb_ack,
    output logic               o_wb_stall,
    output logic [31:0]        o_wb_data,
    output logic [6:0]         o_seg,
    output logic               o_dp,
    output logic [NDIGITS-1:0] o_an
);

    localparam int DW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW       = $clog2(CLK_DIV);
    localparam int SHOW_CYC = CLK_DIV - BLANK_CYC;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NDIGITS - 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Inactive pin levels; XOR with these converts active-high to pin polarity.
    localparam logic               POL     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [6:0]         SEG_OFF = {7{POL}};
    localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{POL}};

    // Hex nibble to active-high gfedcba pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Bus registers
    logic [31:0] value_r;
    logic        ctrl_en_r;
    logic        ctrl_lzb_r;
    logic [7:0]  ctrl_dp_r;
    logic        ack_r;
    logic [31:0] rdata_r;

    // Scan state
    logic [1:0]         state_r;
    logic [DW-1:0]      digit_r;
    logic [CW-1:0]      cnt_r;
    logic [31:0]        shadow_val_r;
    logic [NDIGITS-1:0] shadow_dp_r;
    logic [6:0]         seg_r;
    logic               dp_r;
    logic [NDIGITS-1:0] an_r;

    logic               req_s;
    logic               wr_s;
    logic               rd_s;
    logic [31:0]        ctrl_rd_s;
    logic [1:0]         state_next_s;
    logic [DW-1:0]      digit_next_s;
    logic [CW-1:0]      cnt_next_s;
    logic               load_s;
    logic [31:0]        shadow_val_next_s;
    logic [NDIGITS-1:0] shadow_dp_next_s;
    logic [31:0]        shifted_s;
    logic               blank_s;
    logic               show_lit_s;
    logic [NDIGITS-1:0] an_on_s;
    logic               dp_on_s;
    logic               unused_s;

    assign req_s     = i_wb_cyc & i_wb_stb;
    assign wr_s      = req_s & i_wb_we;
    assign rd_s      = req_s & ~i_wb_we;
    assign ctrl_rd_s = {16'h0000, ctrl_dp_r, 6'b000000, ctrl_lzb_r, ctrl_en_r};
    assign unused_s  = ^i_wb_addr[29:1];

    // The pending ack is dropped as soon as the master abandons the cycle.
    assign o_wb_ack   = ack_r & i_wb_cyc;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_r;
    assign o_seg      = seg_r;
    assign o_dp       = dp_r;
    assign o_an       = an_r;

    // VALUE/CTRL byte-enabled writes, landing on the accepting edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            value_r    <= 32'h0000_0000;
            ctrl_en_r  <= 1'b0;
            ctrl_lzb_r <= 1'b0;
            ctrl_dp_r  <= 8'h00;
        end else if (wr_s) begin
            if (i_wb_addr[0] == 1'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_wb_sel[b]) begin
                        value_r[8*b +: 8] <= i_wb_data[8*b +: 8];
                    end
                end
            end else begin
                if (i_wb_sel[0]) begin
                    ctrl_en_r  <= i_wb_data[0];
                    ctrl_lzb_r <= i_wb_data[1];
                end
                if (i_wb_sel[1]) begin
                    ctrl_dp_r <= i_wb_data[15:8];
                end
            end
        end
    end

    // Ack one cycle after every accepted strobe; reads capture the addressed register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ack_r <= req_s;
            if (rd_s) begin
                rdata_r <= (i_wb_addr[0] == 1'b0) ? value_r : ctrl_rd_s;
            end
        end
    end

    // Scan FSM next-state: OFF -> BLANK -> SHOW -> BLANK(next digit) ..., EN=0 forces OFF.
    always_comb begin
        state_next_s = state_r;
        digit_next_s = digit_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (ctrl_en_r) begin
                    state_next_s = ST_BLANK;
                    digit_next_s = {DW{1'b0}};
                    cnt_next_s   = {CW{1'b0}};
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            ST_BLANK: begin
                if (!ctrl_en_r) begin
                    state_next_s = ST_OFF;
                    digit_next_s = {DW{1'b0}};
                    cnt_next_s   = {CW{1'b0}};
                end else if (cnt_r == BLANK_LAST) begin
                    state_next_s = ST_SHOW;
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + CW'(1);
                end
            end
            ST_SHOW: begin
                if (!ctrl_en_r) begin
                    state_next_s = ST_OFF;
                    digit_next_s = {DW{1'b0}};
                    cnt_next_s   = {CW{1'b0}};
                end else if (cnt_r == SHOW_LAST) begin
                    state_next_s = ST_BLANK;
                    cnt_next_s   = {CW{1'b0}};
                    load_s       = 1'b1;
                    if (digit_r == DIGIT_LAST) begin
                        digit_next_s = {DW{1'b0}};
                    end else begin
                        digit_next_s = digit_r + DW'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_next_s = ST_OFF;
                digit_next_s = {DW{1'b0}};
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // Shadow as it will be after this edge, so pins and shadow update together at slot start.
    always_comb begin
        if (load_s) begin
            shadow_val_next_s = value_r;
            shadow_dp_next_s  = ctrl_dp_r[NDIGITS-1:0];
        end else begin
            shadow_val_next_s = shadow_val_r;
            shadow_dp_next_s  = shadow_dp_r;
        end
        shifted_s  = shadow_val_next_s >> {digit_next_s, 2'b00};
        // Blank when no nonzero nibble exists at or above this digit; digit 0 always shows.
        blank_s    = ctrl_lzb_r && (digit_next_s != {DW{1'b0}}) && (shifted_s == 32'h0000_0000);
        show_lit_s = (state_next_s == ST_SHOW) && !blank_s;
    end

    // Anode one-hot and decimal-point select for the next digit.
    always_comb begin
        an_on_s = {NDIGITS{1'b0}};
        dp_on_s = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (digit_next_s == DW'(k)) begin
                an_on_s[k] = show_lit_s;
                dp_on_s    = shadow_dp_next_s[k];
            end else begin
                an_on_s[k] = 1'b0;
            end
        end
    end

    // Scan state, counters and shadow copy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r      <= ST_OFF;
            digit_r      <= {DW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            shadow_val_r <= 32'h0000_0000;
            shadow_dp_r  <= {NDIGITS{1'b0}};
        end else begin
            state_r      <= state_next_s;
            digit_r      <= digit_next_s;
            cnt_r        <= cnt_next_s;
            shadow_val_r <= shadow_val_next_s;
            shadow_dp_r  <= shadow_dp_next_s;
        end
    end

    // Registered display pins; segments go inactive while scanning is off.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seg_r <= SEG_OFF;
            dp_r  <= POL;
            an_r  <= AN_OFF;
        end else begin
            an_r <= an_on_s ^ AN_OFF;
            if (state_next_s == ST_OFF) begin
                seg_r <= SEG_OFF;
                dp_r  <= POL;
            end else begin
                seg_r <= seg_decode(shifted_s[3:0]) ^ SEG_OFF;
                dp_r  <= dp_on_s ^ POL;
            end
        end
    end

endmodule

// File: tb/tb_wb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_wb_sevenseg_scan
//
// Self-checking bench for wb_sevenseg_scan (4 digits, 8-clock slots, 2 blank
// clocks, active-low pins). A behavioural model tracks the bus registers and
// the number of clocks since scanning started; from that it derives the digit,
// slot phase, shadow snapshot and the expected pins each cycle. Directed cases
// cover the documented scenarios, then a random phase mixes bus traffic.
// -----------------------------------------------------------------------------
module tb_wb_sevenseg_scan;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          wb_cyc   = 1'b0;
    logic          wb_stb   = 1'b0;
    logic          wb_we    = 1'b0;
    logic [29:0]   wb_addr  = 30'h0;
    logic [31:0]   wb_data  = 32'h0;
    logic [3:0]    wb_sel   = 4'h0;
    logic          wb_ack;
    logic          wb_stall;
    logic [31:0]   wb_rdata;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;

    wb_sevenseg_scan #(
        .NDIGITS       (ND),
        .CLK_DIV       (CD),
        .BLANK_CYC     (BC),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wb_cyc  (wb_cyc),
        .i_wb_stb  (wb_stb),
        .i_wb_we   (wb_we),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .i_wb_sel  (wb_sel),
        .o_wb_ack  (wb_ack),
        .o_wb_stall(wb_stall),
        .o_wb_data (wb_rdata),
        .o_seg     (seg),
        .o_dp      (dp),
        .o_an      (an)
    );

    always #5 clk = ~clk;

    // Active-high gfedcba for hex digits 0..F.
    logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state
    logic [31:0]   m_value   = 32'h0;
    logic          m_en      = 1'b0;
    logic          m_lzb     = 1'b0;
    logic [7:0]    m_dp      = 8'h0;
    int            m_run     = -1;     // clocks since scanning started, -1 when off
    logic [31:0]   m_snap    = 32'h0;
    logic [7:0]    m_snap_dp = 8'h0;
    logic          m_pend    = 1'b0;
    logic [31:0]   m_rdata   = 32'h0;
    logic [ND-1:0] e_an      = 4'hF;
    logic [6:0]    e_seg     = 7'h7F;
    logic          e_dp      = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using pre-edge state and inputs.
    task automatic model_edge();
        logic [31:0] ctrl_pre;
        logic [31:0] sh;
        int          digit;
        int          phase;
        logic        lit;
        if (reset) begin
            m_value = 32'h0; m_en = 1'b0; m_lzb = 1'b0; m_dp = 8'h0;
            m_run = -1; m_snap = 32'h0; m_snap_dp = 8'h0;
            m_pend = 1'b0; m_rdata = 32'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            return;
        end
        ctrl_pre = {16'h0, m_dp, 6'h0, m_lzb, m_en};
        if (!m_en) m_run = -1;
        else       m_run = m_run + 1;
        if (m_run >= 0) begin
            digit = (m_run / CD) % ND;
            phase = m_run % CD;
            if (phase == 0) begin
                m_snap    = m_value;
                m_snap_dp = m_dp;
            end
            sh    = m_snap >> (4 * digit);
            lit   = (phase >= BC) && !(m_lzb && digit != 0 && sh == 32'h0);
            e_seg = ~seg_tab[sh[3:0]];
            e_dp  = ~m_snap_dp[digit];
            e_an  = lit ? ~(4'b0001 << digit) : 4'hF;
        end else begin
            e_an = 4'hF;
        end
        m_pend = wb_cyc & wb_stb;
        if (wb_cyc && wb_stb) begin
            if (wb_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel[b]) begin
                        if (!wb_addr[0]) begin
                            m_value[8*b +: 8] = wb_data[8*b +: 8];
                        end else if (b == 0) begin
                            m_en  = wb_data[0];
                            m_lzb = wb_data[1];
                        end else if (b == 1) begin
                            m_dp = wb_data[15:8];
                        end
                    end
                end
            end else begin
                m_rdata = wb_addr[0] ? ctrl_pre : m_value;
            end
        end
    endtask

    // One clock; optionally drop cyc/stb right after the edge; check at the falling edge.
    task automatic step_drop(input bit drop);
        @(posedge clk);
        model_edge();
        if (drop) begin
            #1;
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
        end
        @(negedge clk);
        check_value("an", an, e_an);
        if (m_run >= 0) begin
            check_value("seg", seg, e_seg);
            check_value("dp", dp, e_dp);
        end
        check_value("ack", wb_ack, m_pend & wb_cyc);
        check_value("rdata", wb_rdata, m_rdata);
        check_value("stall", wb_stall, 1'b0);
    endtask

    task automatic step();
        step_drop(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wb_op(input bit we, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit drop,
                         output logic [31:0] rd, output logic ack);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_addr = a; wb_data = d; wb_sel = s;
        step_drop(drop);
        rd  = wb_rdata;
        ack = wb_ack;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        ack;
        wb_op(1'b1, a, d, s, 1'b0, rd, ack);
    endtask

    task automatic wb_read(input logic [29:0] a, output logic [31:0] rd, output logic ack);
        wb_op(1'b0, a, 32'h0, 4'hF, 1'b0, rd, ack);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] r;
        logic [31:0] d;
        logic        ack;
        int          acks;
        int          op;

        // Reset state
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_value("rst_an", an, 4'hF);
        check_value("rst_seg", seg, 7'h7F);
        check_value("rst_dp", dp, 1'b1);
        check_value("rst_ack", wb_ack, 1'b0);
        check_value("rst_data", wb_rdata, 32'h0);
        wb_read(30'd0, rd, ack);
        check_value("rd0_ack", ack, 1'b1);
        check_value("rd0_data", rd, 32'h0);
        wb_read(30'd1, rd, ack);
        check_value("rd1_ack", ack, 1'b1);
        check_value("rd1_data", rd, 32'h0);

        // Basic scan of 0x1234
        wb_write(30'd0, 32'h0000_1234, 4'hF);
        wb_write(30'd1, 32'h0000_0001, 4'hF);
        idle(2);
        check_value("d0_blank_an", an, 4'hF);
        idle(1);
        check_value("d0_an", an, 4'hE);
        check_value("d0_seg", seg, 7'h19);
        idle(6);
        check_value("d1_blank_an", an, 4'hF);
        check_value("d1_seg", seg, 7'h30);
        idle(2);
        check_value("d1_an", an, 4'hD);
        idle(24);
        check_value("period_an", an, 4'hE);

        // Byte enables and CTRL read-only bits
        wb_write(30'd0, 32'h0000_1234, 4'hF);
        wb_write(30'd0, 32'h0000_AB00, 4'b0010);
        wb_read(30'd0, rd, ack);
        check_value("sel_value", rd, 32'h0000_AB34);
        wb_write(30'd1, 32'hFFFF_FFFF, 4'hF);
        wb_read(30'd1, rd, ack);
        check_value("ctrl_ro", rd, 32'h0000_FF03);

        // Leading-zero blanking with DP on a blanked digit
        wb_write(30'd1, 32'h0, 4'hF);
        wb_write(30'd0, 32'h0000_0005, 4'hF);
        wb_write(30'd1, 32'h0000_0203, 4'hF);
        idle(3);
        check_value("lzb_d0_an", an, 4'hE);
        check_value("lzb_d0_seg", seg, 7'h12);
        idle(6);
        check_value("lzb_d1_dp", dp, 1'b0);
        idle(2);
        check_value("lzb_d1_an", an, 4'hF);
        check_value("lzb_d1_dp_show", dp, 1'b0);
        idle(22);

        // EN cleared during SHOW, then restart at digit 0
        idle(3);
        check_value("pre_dis_an", an, 4'hE);
        wb_write(30'd1, 32'h0, 4'hF);
        idle(1);
        check_value("dis_an", an, 4'hF);
        wb_write(30'd1, 32'h1, 4'hF);
        idle(2);
        check_value("re_blank_an", an, 4'hF);
        idle(1);
        check_value("re_d0_an", an, 4'hE);
        check_value("re_d0_seg", seg, 7'h12);

        // Reset during SHOW
        idle(2);
        reset = 1'b1;
        step();
        check_value("rst_show_an", an, 4'hF);
        reset = 1'b0;
        step();

        // Three back-to-back strobes, then a cancelled ack
        acks = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            wb_addr = 30'(i % 2);
            step();
            if (wb_ack) acks++;
        end
        wb_stb = 1'b0;
        step();
        check_value("b2b_after", wb_ack, 1'b0);
        wb_cyc = 1'b0;
        check_value("b2b_acks", acks, 3);
        wb_op(1'b0, 30'd0, 32'h0, 4'hF, 1'b1, rd, ack);
        check_value("drop_ack", ack, 1'b0);
        idle(1);

        // Randomised traffic against the model
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            r  = $urandom;
            case (op)
                0, 1, 2: begin
                    d = $urandom >> $urandom_range(0, 31);
                    wb_op(1'b1, {r[28:0], 1'b0}, d,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 1'b0, rd, ack);
                end
                3, 4: begin
                    d = $urandom;
                    d[0] = ($urandom_range(0, 7) != 0);
                    wb_op(1'b1, {r[28:0], 1'b1}, d, 4'($urandom | 1), 1'b0, rd, ack);
                end
                5, 6: wb_op(1'b0, r[29:0], 32'h0, 4'hF, 1'b0, rd, ack);
                7:    wb_op(r[31], r[29:0], $urandom, 4'hF, 1'b1, rd, ack);
                8:    idle($urandom_range(1, 12));
                default: begin
                    if (r[31:29] == 3'b000) begin
                        reset = 1'b1;
                        step();
                        reset = 1'b0;
                    end else begin
                        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
                        for (int i = 0; i < 3; i++) begin
                            wb_addr = 30'($urandom);
                            step();
                        end
                        wb_cyc = 1'b0; wb_stb = 1'b0;
                    end
                end
            endcase
            idle($urandom_range(0, 3));
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
